// File: rtl/alu_seq_muldiv.sv
// alu_seq_muldiv: multi-cycle MUL / DIVU / REMU sequencer that borrows the
// shared execute-stage ALU, one ALU operation per clock.
//
// Ports:
//   clk, reset        - single clock, synchronous active-high reset
//   start, op         - request (sampled only in IDLE); op 00 MUL, 01 DIVU,
//                       10 REMU, 11 reserved (completes with result 0)
//   rs1, rs2          - operands, captured together with start
//   busy              - high in every state except IDLE
//   done              - one-cycle completion pulse
//   result            - final value, valid with done, held until next done
//   alu_a/alu_b/alu_ctrl - operands and control driven to the shared ALU
//   alu_result        - combinational ALU output fed back to this block
//
// All outputs are registered. Next-state and next-register values are formed
// in one combinational process and the ALU drive is derived from those next
// values, so the registered ALU outputs always match the state they belong to.
module alu_seq_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REMU = 2'b10;

  localparam logic [3:0] CTRL_ADD  = 4'b0000;
  localparam logic [3:0] CTRL_SUB  = 4'b0001;
  localparam logic [3:0] CTRL_SLTU = 4'b1000;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MUL_STEP = 3'd1,
    DIV_CMP  = 3'd2,
    DIV_SUB  = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t           state_r, state_s;
  logic [1:0]       op_r, op_s;
  logic [CNT_W-1:0] count_r, count_s;
  logic [WIDTH-1:0] acc_r, acc_s;
  logic [WIDTH-1:0] mcand_r, mcand_s;
  logic [WIDTH-1:0] mplier_r, mplier_s;
  logic [WIDTH-1:0] rem_r, rem_s;
  logic [WIDTH-1:0] quot_r, quot_s;
  logic [WIDTH-1:0] dvs_r, dvs_s;
  logic             ge_r, ge_s;
  logic [WIDTH-1:0] result_r, result_s;
  logic             busy_r, done_r;
  logic [WIDTH-1:0] alu_a_r, alu_a_s;
  logic [WIDTH-1:0] alu_b_r, alu_b_s;
  logic [3:0]       alu_ctrl_r, alu_ctrl_s;
  logic [WIDTH-1:0] trial_s;

  assign busy     = busy_r;
  assign done     = done_r;
  assign result   = result_r;
  assign alu_a    = alu_a_r;
  assign alu_b    = alu_b_r;
  assign alu_ctrl = alu_ctrl_r;

  // Restoring-division shift: remainder gains the next dividend bit. The bit
  // shifted out of rem (ovf) means the true trial value is >= 2^WIDTH.
  assign trial_s = {rem_r[WIDTH-2:0], quot_r[WIDTH-1]};

  // Next-state, datapath-register and ALU-drive computation.
  always_comb begin
    state_s  = state_r;
    op_s     = op_r;
    count_s  = count_r;
    acc_s    = acc_r;
    mcand_s  = mcand_r;
    mplier_s = mplier_r;
    rem_s    = rem_r;
    quot_s   = quot_r;
    dvs_s    = dvs_r;
    ge_s     = ge_r;
    result_s = result_r;

    case (state_r)
      IDLE: begin
        if (start) begin
          op_s    = op;
          count_s = '0;
          case (op)
            OP_MUL: begin
              acc_s    = '0;
              mcand_s  = rs1;
              mplier_s = rs2;
              state_s  = MUL_STEP;
            end
            OP_DIVU, OP_REMU: begin
              if (rs2 != '0) begin
                rem_s   = '0;
                quot_s  = rs1;
                dvs_s   = rs2;
                state_s = DIV_CMP;
              end else begin
                // Divide by zero follows the RV32M convention.
                result_s = (op == OP_DIVU) ? '1 : rs1;
                state_s  = DONE;
              end
            end
            default: begin
              result_s = '0;
              state_s  = DONE;
            end
          endcase
        end else begin
          state_s = IDLE;
        end
      end
      MUL_STEP: begin
        if (mplier_r[0]) begin
          acc_s = alu_result;
        end else begin
          acc_s = acc_r;
        end
        mcand_s  = mcand_r << 1;
        mplier_s = mplier_r >> 1;
        count_s  = count_r + CNT_W'(1);
        if (count_r == LAST_STEP) begin
          result_s = acc_s;
          state_s  = DONE;
        end else begin
          state_s = MUL_STEP;
        end
      end
      DIV_CMP: begin
        // alu_result[0] is trial < dvs; any overflowed trial is >= dvs.
        ge_s    = rem_r[WIDTH-1] | ~alu_result[0];
        rem_s   = trial_s;
        quot_s  = quot_r << 1;
        state_s = DIV_SUB;
      end
      DIV_SUB: begin
        // The SUB runs every pair so latency does not depend on the data;
        // the modulo difference is exact because the true remainder < dvs.
        if (ge_r) begin
          rem_s  = alu_result;
          quot_s = {quot_r[WIDTH-1:1], 1'b1};
        end else begin
          rem_s  = rem_r;
          quot_s = quot_r;
        end
        count_s = count_r + CNT_W'(1);
        if (count_r == LAST_STEP) begin
          result_s = (op_r == OP_DIVU) ? quot_s : rem_s;
          state_s  = DONE;
        end else begin
          state_s = DIV_CMP;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    // ALU drive for the state being entered, built from next-cycle values.
    case (state_s)
      MUL_STEP: begin
        alu_a_s    = acc_s;
        alu_b_s    = mcand_s;
        alu_ctrl_s = CTRL_ADD;
      end
      DIV_CMP: begin
        alu_a_s    = {rem_s[WIDTH-2:0], quot_s[WIDTH-1]};
        alu_b_s    = dvs_s;
        alu_ctrl_s = CTRL_SLTU;
      end
      DIV_SUB: begin
        alu_a_s    = rem_s;
        alu_b_s    = dvs_s;
        alu_ctrl_s = CTRL_SUB;
      end
      default: begin
        alu_a_s    = '0;
        alu_b_s    = '0;
        alu_ctrl_s = CTRL_ADD;
      end
    endcase
  end

  // State, datapath and output registers; reset aborts any operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      op_r       <= 2'b00;
      count_r    <= '0;
      acc_r      <= '0;
      mcand_r    <= '0;
      mplier_r   <= '0;
      rem_r      <= '0;
      quot_r     <= '0;
      dvs_r      <= '0;
      ge_r       <= 1'b0;
      result_r   <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      alu_a_r    <= '0;
      alu_b_r    <= '0;
      alu_ctrl_r <= 4'b0000;
    end else begin
      state_r    <= state_s;
      op_r       <= op_s;
      count_r    <= count_s;
      acc_r      <= acc_s;
      mcand_r    <= mcand_s;
      mplier_r   <= mplier_s;
      rem_r      <= rem_s;
      quot_r     <= quot_s;
      dvs_r      <= dvs_s;
      ge_r       <= ge_s;
      result_r   <= result_s;
      busy_r     <= (state_s != IDLE);
      done_r     <= (state_s == DONE);
      alu_a_r    <= alu_a_s;
      alu_b_r    <= alu_b_s;
      alu_ctrl_r <= alu_ctrl_s;
    end
  end

endmodule

// File: tb/tb_alu_seq_muldiv.sv
// Scoreboard bench for alu_seq_muldiv: the stimulus process pushes expected
// result / completion cycle / busy length; a monitor pops on every done.
module tb_alu_seq_muldiv;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_result;

  typedef struct {
    logic [31:0] res;
    int          cyc;
    int          busy_n;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   busy_cnt = 0;

  alu_seq_muldiv #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .rs1        (rs1),
    .rs2        (rs2),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result)
  );

  // Shared ALU stand-in.
  always_comb begin
    case (alu_ctrl)
      4'b0000: alu_result = alu_a + alu_b;
      4'b0001: alu_result = alu_a - alu_b;
      4'b1000: alu_result = {31'd0, (alu_a < alu_b)};
      default: alu_result = 32'd0;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare every done against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got result %h with empty scoreboard", result);
        end else begin
          e = sb.pop_front();
          chk("result", result, e.res);
          chk("done_cycle", 32'(cyc), 32'(e.cyc));
          chk("busy_cycles", 32'(busy_cnt), 32'(e.busy_n));
        end
        busy_cnt = 0;
      end
    end
  end

  // Start one operation; the DUT captures it at the edge this task ends on.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input int bn);
    exp_t e;
    @(posedge clk); #1;
    op = o; rs1 = a; rs2 = b; start = 1'b1;
    e.res = exp; e.cyc = cyc + lat; e.busy_n = bn;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    op = ~o; rs1 = 32'hDEAD_BEEF; rs2 = 32'h0BAD_F00D;
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (sb.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got pending=%0d expected 0", name, sb.size());
    end
  endtask

  initial begin
    exp_t e;
    int   errs;
    reset = 1'b1; start = 1'b0; op = 2'b00; rs1 = 32'd0; rs2 = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
    reset = 1'b0;

    // Multiply.
    issue(2'b00, 32'h0000_1234, 32'h0000_5678, 32'h0626_0060, 33, 33);
    wait_idle("mul1");
    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33, 33);
    errs = 0;
    for (int i = 0; i < 32; i++) begin
      if (alu_ctrl !== 4'b0000 || busy !== 1'b1) errs++;
      @(posedge clk); #1;
    end
    chk("mul_alu_ctrl_errs", 32'(errs), 32'd0);
    wait_idle("mul2");
    issue(2'b00, 32'h1357_9BDF, 32'h0000_0000, 32'h0000_0000, 33, 33);
    wait_idle("mul3");

    // Divide / remainder, including the overflowed-trial path.
    issue(2'b01, 32'd100, 32'd7, 32'd14, 65, 65);
    wait_idle("divu1");
    issue(2'b10, 32'd100, 32'd7, 32'd2, 65, 65);
    wait_idle("remu1");
    issue(2'b01, 32'hFFFF_FFFF, 32'h8000_0001, 32'h0000_0001, 65, 65);
    wait_idle("divu2");
    issue(2'b10, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 65, 65);
    wait_idle("remu2");

    // Divide by zero and reserved op complete immediately.
    issue(2'b01, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1, 1);
    wait_idle("divu0");
    issue(2'b10, 32'h1234_5678, 32'd0, 32'h1234_5678, 1, 1);
    wait_idle("remu0");
    issue(2'b11, 32'h1234_5678, 32'h9, 32'd0, 1, 1);
    wait_idle("rsvd");

    // Start pulses while busy are ignored.
    issue(2'b01, 32'd100, 32'd7, 32'd14, 65, 65);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      start = 1'b1; op = 2'(i); rs1 = 32'(i * 77 + 5); rs2 = 32'(i + 3);
      @(posedge clk); #1;
      start = 1'b0;
    end
    wait_idle("busy_pulses");

    // Start held high: second request accepted in the IDLE cycle after done.
    @(posedge clk); #1;
    op = 2'b01; rs1 = 32'd100; rs2 = 32'd7; start = 1'b1;
    e.res = 32'd14; e.cyc = cyc + 65; e.busy_n = 65;
    sb.push_back(e);
    e.res = 32'd15; e.cyc = cyc + 99; e.busy_n = 33;
    sb.push_back(e);
    @(posedge clk); #1;
    op = 2'b00; rs1 = 32'd3; rs2 = 32'd5;
    for (int i = 0; i < 300; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk); #1;
    end
    start = 1'b0;
    wait_idle("held_start");

    // Reset in the middle of a divide.
    issue(2'b01, 32'd1000, 32'd3, 32'd333, 65, 65);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_result", result, 32'd0);
    chk("abort_alu_a", alu_a, 32'd0);
    chk("abort_alu_b", alu_b, 32'd0);
    chk("abort_alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
    reset = 1'b0;
    issue(2'b00, 32'd3, 32'd5, 32'd15, 33, 33);
    wait_idle("post_reset_mul");

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
